// File: rtl/xbus_lsu.sv
// xbus_lsu: load/store unit between the core memory stage and the xbus.
// Define XBUS_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module xbus_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   rdata,
    output logic              resp_err,
    output logic              xbus_req,
    output logic              xbus_we,
    output logic [XLEN/8-1:0] xbus_be,
    output logic [ADDR_W-1:0] xbus_addr,
    output logic [XLEN-1:0]   xbus_wdata,
    input  logic              xbus_ack,
    input  logic [XLEN-1:0]   xbus_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam logic [NB-1:0] ONE = NB'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
`ifdef XBUS_MISALIGN_SPLIT_EN
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_BEAT1 = 3'd4;
`endif

    function automatic logic too_big(input logic [1:0] sz);
        return (1 << sz) > NB;
    endfunction

    function automatic logic crosses(input logic [OB-1:0] o,
                                     input logic [1:0] sz);
        return (int'(o) + (1 << sz)) > NB;
    endfunction

    // Keep the low S bytes, then sign- or zero-extend to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [2:0] f3);
        int sh;
        logic [XLEN-1:0] up;
        sh = XLEN - 8 * (1 << f3[1:0]);
        if (sh <= 0) return raw;
        up = raw << sh;
        if (f3[2]) return up >> sh;
        return $signed(up) >>> sh;
    endfunction

    logic [2:0]        st;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic              r_err;
    logic [XLEN-1:0]   rdata_q;
`ifdef XBUS_MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   beat0_q;
    logic              cross_r;
    logic [XLEN-1:0]   b_lo;
    logic [XLEN-1:0]   b_hi;
`endif

    logic [OB-1:0]     off;
    logic [NB-1:0]     mask;
    logic [ADDR_W-1:0] base;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   rd_ext;
    logic              acc_err;

    assign off  = r_addr[OB-1:0];
    assign base = {r_addr[ADDR_W-1:OB], {OB{1'b0}}};
    assign mask = (ONE << (1 << r_f3[1:0])) - ONE;

`ifdef XBUS_MISALIGN_SPLIT_EN
    assign acc_err = too_big(funct3[1:0]);
    assign cross_r = crosses(off, r_f3[1:0]);
    assign b_lo    = (st == S_BEAT1) ? beat0_q : xbus_rdata;
    assign b_hi    = (st == S_BEAT1) ? xbus_rdata : '0;
    assign raw     = (b_lo >> (8 * int'(off)))
                   | (b_hi << (8 * (NB - int'(off))));
`else
    assign acc_err = too_big(funct3[1:0])
                   | crosses(addr[OB-1:0], funct3[1:0]);
    assign raw     = xbus_rdata >> (8 * int'(off));
`endif

    assign rd_ext = r_we ? '0 : extend(raw, r_f3);

    always_comb begin
        xbus_req   = 1'b0;
        xbus_be    = '0;
        xbus_addr  = '0;
        xbus_wdata = '0;
        case (st)
            S_BEAT0: begin
                xbus_req   = 1'b1;
                xbus_be    = mask << off;
                xbus_addr  = base;
                xbus_wdata = r_wdata << (8 * int'(off));
            end
`ifdef XBUS_MISALIGN_SPLIT_EN
            S_BEAT1: begin
                xbus_req   = 1'b1;
                xbus_be    = mask >> (NB - int'(off));
                xbus_addr  = base + ADDR_W'(NB);
                xbus_wdata = r_wdata >> (8 * (NB - int'(off)));
            end
`endif
            default: ;
        endcase
    end

    assign xbus_we    = xbus_req & r_we;
    assign req_ready  = (st == S_IDLE);
    assign resp_valid = (st == S_RESP);
    assign resp_err   = (st == S_RESP) & r_err;
    assign rdata      = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            r_addr  <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            rdata_q <= '0;
`ifdef XBUS_MISALIGN_SPLIT_EN
            beat0_q <= '0;
`endif
        end else begin
            case (st)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= addr;
                        r_f3    <= funct3;
                        r_we    <= req_we;
                        r_wdata <= wdata;
                        r_err   <= acc_err;
                        if (acc_err) begin
                            rdata_q <= '0;
                            st      <= S_RESP;
                        end else begin
                            st <= S_BEAT0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (xbus_ack) begin
`ifdef XBUS_MISALIGN_SPLIT_EN
                        if (cross_r) begin
                            beat0_q <= xbus_rdata;
                            st      <= S_GAP;
                        end else begin
                            rdata_q <= rd_ext;
                            st      <= S_RESP;
                        end
`else
                        rdata_q <= rd_ext;
                        st      <= S_RESP;
`endif
                    end
                end
`ifdef XBUS_MISALIGN_SPLIT_EN
                // Bus needs one idle cycle between beats.
                S_GAP: st <= S_BEAT1;
                S_BEAT1: begin
                    if (xbus_ack) begin
                        rdata_q <= rd_ext;
                        st      <= S_RESP;
                    end
                end
`endif
                S_RESP:  st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xbus_lsu.sv
// tb_xbus_lsu: directed checks of xbus_lsu at XLEN 32 and 64.
// Split-dependent expectations follow XBUS_MISALIGN_SPLIT_EN.
module tb_xbus_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_funct3;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_resp_valid, a_resp_err;
    logic        a_xbus_req, a_xbus_we, a_xbus_ack;
    logic [3:0]  a_xbus_be;
    logic [31:0] a_xbus_addr, a_xbus_wdata, a_xbus_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_funct3;
    logic [31:0] b_addr, b_xbus_addr;
    logic [63:0] b_wdata, b_rdata, b_xbus_wdata, b_xbus_rdata;
    logic        b_resp_valid, b_resp_err;
    logic        b_xbus_req, b_xbus_we, b_xbus_ack;
    logic [7:0]  b_xbus_be;

    xbus_lsu #(.XLEN(32), .ADDR_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .funct3(a_funct3),
        .addr(a_addr), .wdata(a_wdata),
        .resp_valid(a_resp_valid), .rdata(a_rdata),
        .resp_err(a_resp_err),
        .xbus_req(a_xbus_req), .xbus_we(a_xbus_we),
        .xbus_be(a_xbus_be), .xbus_addr(a_xbus_addr),
        .xbus_wdata(a_xbus_wdata), .xbus_ack(a_xbus_ack),
        .xbus_rdata(a_xbus_rdata)
    );

    xbus_lsu #(.XLEN(64), .ADDR_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .funct3(b_funct3),
        .addr(b_addr), .wdata(b_wdata),
        .resp_valid(b_resp_valid), .rdata(b_rdata),
        .resp_err(b_resp_err),
        .xbus_req(b_xbus_req), .xbus_we(b_xbus_we),
        .xbus_be(b_xbus_be), .xbus_addr(b_xbus_addr),
        .xbus_wdata(b_xbus_wdata), .xbus_ack(b_xbus_ack),
        .xbus_rdata(b_xbus_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_send(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] ad,
                          input logic [31:0] wd);
        @(negedge clk);
        chk({tag, ".ready"}, 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_funct3    = f3;
        a_addr      = ad;
        a_wdata     = wd;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_we    = 1'b0;
        a_funct3    = 3'b111;
        a_addr      = 32'hFFFF_FFFF;
        a_wdata     = 32'hFFFF_FFFF;
    endtask

    task automatic a_beat(input string tag, input logic [31:0] ea,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic ewe, input logic [31:0] rd);
        chk({tag, ".req"}, 64'(a_xbus_req), 64'd1);
        chk({tag, ".addr"}, 64'(a_xbus_addr), 64'(ea));
        chk({tag, ".be"}, 64'(a_xbus_be), 64'(ebe));
        chk({tag, ".wdata"}, 64'(a_xbus_wdata), 64'(ewd));
        chk({tag, ".we"}, 64'(a_xbus_we), 64'(ewe));
        a_xbus_ack   = 1'b1;
        a_xbus_rdata = rd;
        @(negedge clk);
        a_xbus_ack   = 1'b0;
        a_xbus_rdata = 32'h0BAD_0BAD;
        chk({tag, ".drop"}, 64'(a_xbus_req), 64'd0);
    endtask

    task automatic a_resp(input string tag, input logic [31:0] erd,
                          input logic eerr);
        chk({tag, ".valid"}, 64'(a_resp_valid), 64'd1);
        chk({tag, ".rdata"}, 64'(a_rdata), 64'(erd));
        chk({tag, ".err"}, 64'(a_resp_err), 64'(eerr));
        @(negedge clk);
        chk({tag, ".pulse"}, 64'(a_resp_valid), 64'd0);
        chk({tag, ".hold"}, 64'(a_rdata), 64'(erd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_req_valid = 0; a_req_we = 0; a_funct3 = 0;
        a_addr = 0; a_wdata = 0; a_xbus_ack = 0; a_xbus_rdata = 0;
        b_req_valid = 0; b_req_we = 0; b_funct3 = 0;
        b_addr = 0; b_wdata = 0; b_xbus_ack = 0; b_xbus_rdata = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ready", 64'(a_req_ready), 64'd1);
        chk("rst.valid", 64'(a_resp_valid), 64'd0);
        chk("rst.err", 64'(a_resp_err), 64'd0);
        chk("rst.req", 64'(a_xbus_req), 64'd0);
        chk("rst.rdata", 64'(a_rdata), 64'd0);
        chk("rst.be", 64'(a_xbus_be), 64'd0);
        chk("rst.addr", 64'(a_xbus_addr), 64'd0);
        chk("rst.wdata", 64'(a_xbus_wdata), 64'd0);
        chk("rst.b_ready", 64'(b_req_ready), 64'd1);
        chk("rst.b_req", 64'(b_xbus_req), 64'd0);
        rst_n = 1'b1;

        a_send("lw", 1'b0, 3'b010, 32'h100, 32'h0);
        a_beat("lw.b0", 32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
        a_resp("lw", 32'hDEAD_BEEF, 1'b0);

        a_send("lb", 1'b0, 3'b000, 32'h103, 32'h0);
        a_beat("lb.b0", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h8012_3456);
        a_resp("lb", 32'hFFFF_FF80, 1'b0);

        a_send("lbu", 1'b0, 3'b100, 32'h103, 32'h0);
        a_beat("lbu.b0", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h8012_3456);
        a_resp("lbu", 32'h0000_0080, 1'b0);

        a_send("lh", 1'b0, 3'b001, 32'h102, 32'h0);
        a_beat("lh.b0", 32'h100, 4'b1100, 32'h0, 1'b0, 32'h8001_7777);
        a_resp("lh", 32'hFFFF_8001, 1'b0);

        a_send("sh", 1'b1, 3'b001, 32'h201, 32'h0000_ABCD);
        a_beat("sh.b0", 32'h200, 4'b0110, 32'h00AB_CD00, 1'b1,
               32'hFFFF_FFFF);
        a_resp("sh", 32'h0, 1'b0);

        a_send("sb", 1'b1, 3'b000, 32'h003, 32'h0000_00A5);
        a_beat("sb.b0", 32'h000, 4'b1000, 32'hA500_0000, 1'b1,
               32'h1234_5678);
        a_resp("sb", 32'h0, 1'b0);

        a_send("lw0", 1'b0, 3'b010, 32'h100, 32'h0);
        a_beat("lw0.b0", 32'h100, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        a_resp("lw0", 32'hCAFE_F00D, 1'b0);

`ifdef XBUS_MISALIGN_SPLIT_EN
        a_send("split", 1'b0, 3'b010, 32'h302, 32'h0);
        a_beat("split.b0", 32'h300, 4'b1100, 32'h0, 1'b0, 32'h1122_3344);
        @(negedge clk);
        a_beat("split.b1", 32'h304, 4'b0011, 32'h0, 1'b0, 32'h5566_7788);
        a_resp("split", 32'h7788_1122, 1'b0);
`else
        a_send("split", 1'b0, 3'b010, 32'h302, 32'h0);
        chk("split.req", 64'(a_xbus_req), 64'd0);
        a_resp("split", 32'h0, 1'b1);
        chk("split.idle", 64'(a_xbus_req), 64'd0);
`endif

        a_send("ld32", 1'b0, 3'b011, 32'h400, 32'h0);
        chk("ld32.req", 64'(a_xbus_req), 64'd0);
        a_resp("ld32", 32'h0, 1'b1);
        chk("ld32.idle", 64'(a_xbus_req), 64'd0);

        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0;
        b_funct3 = 3'b010; b_addr = 32'h0C;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("b.lw.req", 64'(b_xbus_req), 64'd1);
        chk("b.lw.addr", 64'(b_xbus_addr), 64'h08);
        chk("b.lw.be", 64'(b_xbus_be), 64'hF0);
        b_xbus_ack = 1'b1;
        b_xbus_rdata = 64'hCAFE_BABE_1234_5678;
        @(negedge clk);
        b_xbus_ack = 1'b0;
        chk("b.lw.valid", 64'(b_resp_valid), 64'd1);
        chk("b.lw.rdata", b_rdata, 64'hFFFF_FFFF_CAFE_BABE);
        chk("b.lw.err", 64'(b_resp_err), 64'd0);

        @(negedge clk);
        b_req_valid = 1'b1;
`ifdef XBUS_MISALIGN_SPLIT_EN
        b_funct3 = 3'b010; b_addr = 32'h0E;
`else
        b_funct3 = 3'b011; b_addr = 32'h08;
`endif
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("b.rst.req", 64'(b_xbus_req), 64'd1);
        chk("b.rst.addr", 64'(b_xbus_addr), 64'h08);
`ifdef XBUS_MISALIGN_SPLIT_EN
        chk("b.rst.be", 64'(b_xbus_be), 64'hC0);
`else
        chk("b.rst.be", 64'(b_xbus_be), 64'hFF);
`endif
        @(negedge clk);
        chk("b.rst.wait", 64'(b_xbus_req), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("b.rst.idle_req", 64'(b_xbus_req), 64'd0);
        chk("b.rst.ready", 64'(b_req_ready), 64'd1);
        chk("b.rst.valid", 64'(b_resp_valid), 64'd0);
        rst_n = 1'b1;
        b_xbus_ack = 1'b1;
        b_xbus_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        b_xbus_ack = 1'b0;
        chk("b.late.valid", 64'(b_resp_valid), 64'd0);
        chk("b.late.req", 64'(b_xbus_req), 64'd0);
        @(negedge clk);
        chk("b.late.valid2", 64'(b_resp_valid), 64'd0);
        chk("b.late.ready", 64'(b_req_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xbus_lsu.md
Name: xbus_lsu

Overview:
- Sequential load/store unit between the core memory stage and the xbus.
- Accepts one access per handshake and generates byte enables and lane-shifted write data.
- Extracts and sign/zero-extends read data.
- Parametrised in data width. Runs a multi-beat bus handshake so that accesses crossing a bus-word boundary can be split into two beats.

Parameters:
- XLEN, 32, data/bus width in bits; legal values 32 or 64. NB = XLEN/8 bytes per bus word, OB = log2(NB).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  [2] 1 = unsigned load, 0 = signed load; [1:0] size: 00 byte, 01 half, 10 word, 11 double
- addr  in  ADDR_W  byte address
- wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected; qualified by resp_valid
- xbus_req  out  1  bus request
- xbus_we  out  1  bus write
- xbus_be  out  NB  byte enables
- xbus_addr  out  ADDR_W  bus-word-aligned address, low OB bits = 0
- xbus_wdata  out  XLEN  lane-aligned write data
- xbus_ack  in  1  beat complete; sampled only while xbus_req = 1
- xbus_rdata  in  XLEN  read data; valid in the xbus_ack cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; xbus_req = 0. rdata, xbus_be, xbus_addr and xbus_wdata are all 0.
- Request capture:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a clock edge where req_valid && req_ready.
  - At acceptance, addr, funct3, req_we and wdata are registered. Core inputs are ignored after acceptance.
- Decode from the registered request:
  - size S = 1 << funct3[1:0]; offset O = addr[OB-1:0].
  - illegal = (S > NB).
  - cross = (O + S > NB).
  - An access that is unaligned but does not cross a bus word (e.g. half at O = 1, XLEN = 32) is a single beat.
- State machine:
  - IDLE -> BEAT0 on accept, if the access is legal and not a rejected cross.
  - IDLE -> RESP on accept, if illegal (or cross without the optional feature); resp_err = 1.
  - BEAT0: xbus_req = 1 until xbus_ack. On ack -> BEAT1 if cross, else -> RESP.
  - BEAT1: xbus_req = 1 until xbus_ack. On ack -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
- Bus outputs:
  - Held stable while xbus_req = 1. xbus_req drops in the cycle after ack; there are no back-to-back beats without a deassert cycle.
  - BEAT0: xbus_addr = {addr[ADDR_W-1:OB], 0}; xbus_be = (((1<<S)-1) << O) truncated to NB bits; xbus_wdata = (wdata << 8*O) truncated.
  - BEAT1: xbus_addr = BEAT0 address + NB (wraps modulo 2^ADDR_W); xbus_be = ((1<<S)-1) >> (NB-O); xbus_wdata = wdata >> 8*(NB-O).
  - xbus_we = registered req_we in both beats.
- Read assembly:
  - Beat0 data is captured on its ack.
  - raw = (beat0 >> 8*O) | (cross ? beat1 << 8*(NB-O) : 0).
  - The result is masked to S bytes, then sign-extended if funct3[2] = 0, zero-extended otherwise.
  - size = NB passes through with no extension.
- Latency: accepted at edge T. BEAT0 xbus_req is visible in cycle T+1; with zero-wait ack, resp_valid is high in T+2. A split access gives resp_valid at T+4 at earliest. An error gives resp_valid at T+1.
- Reset mid-operation: rst_n low at any edge forces IDLE and drops xbus_req and resp_valid. A bus ack arriving afterwards is ignored.
- Response: resp_valid has no backpressure; the core must accept it. rdata holds its value until the next response.

Optional Feature:
- Macro: XBUS_MISALIGN_SPLIT_EN.
- Defined: boundary-crossing accesses are split into two bus beats as described above.
- Undefined: cross -> RESP with resp_err = 1 and no bus activity. BEAT1 logic and the beat0 capture register are removed.

Test Plan:
- XLEN = 32, load word addr 0x100, xbus_rdata 0xDEADBEEF, zero-wait ack:
  - xbus_addr = 0x100, be = 1111.
  - resp_valid 2 cycles after accept, rdata = 0xDEADBEEF.
- XLEN = 32, LB (funct3 000) addr 0x103, xbus_rdata 0x80123456:
  - be = 1000, rdata = 0xFFFFFF80.
  - The same access with LBU (funct3 100) gives rdata = 0x00000080.
- XLEN = 32, store half addr 0x201, wdata 0x0000ABCD:
  - Single beat, xbus_addr = 0x200, be = 0110, xbus_wdata = 0x00ABCD00.
- XLEN = 32, split enabled, load word addr 0x302:
  - beat0 addr 0x300, be 1100, rdata 0x11223344; beat1 addr 0x304, be 0011, rdata 0x55667788.
  - rdata = 0x77881122.
  - With split disabled: resp_err = 1 and xbus_req never asserts.
- XLEN = 32, funct3 011 (double): resp_err = 1, rdata = 0, no bus request, resp_valid 1 cycle after accept.
- XLEN = 64, split load word addr 0x0E held with ack delayed 3 cycles; rst_n pulled low during BEAT0:
  - Next edge: state IDLE, xbus_req = 0, req_ready = 1.
  - The late ack produces no resp_valid.
